seq_arith_unit: RTL and testbench
=================================

SEQ_ARITH_UNIT -- requirements
Module: seq_arith_unit

Interface
REQ-001 Parameter WIDTH, default WORD_SIZE (19), operand/result width in bits, legal range 4..32.
REQ-002 Parameter OPW, default OPCODE_SIZE, opcode width.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port in_valid  input  1  request present.
REQ-006 Port in_ready  output  1  unit can accept a request.
REQ-007 Port opcode  input  OPW  operation select; encodings from the opcodes package.
REQ-008 Port operand_1  input  WIDTH  first operand, unsigned.
REQ-009 Port operand_2  input  WIDTH  second operand, unsigned; ignored by INC/DEC.
REQ-010 Port out_valid  output  1  result present.
REQ-011 Port out_ready  input  1  consumer accepts result.
REQ-012 Port result  output  WIDTH  sum, difference, low product or quotient.
REQ-013 Port remainder  output  WIDTH  DIV remainder; 0 for all other ops.
REQ-014 Port carry  output  1  carry-out (ADD, INC), borrow (SUB, DEC), product overflow (MUL); 0 for DIV.
REQ-015 Port zero  output  1  result equals 0.
REQ-016 Port div_by_zero  output  1  DIV issued with operand_2 = 0.
REQ-017 Port illegal_op  output  1  opcode not in {ADD, SUB, MUL, DIV, INC, DEC}.

Function
REQ-018 FSM states IDLE, EXEC, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-019 Accept on the edge where in_valid and in_ready are both 1: latch opcode and operands, go IDLE->EXEC.
REQ-020 ADD, SUB, INC, DEC, illegal opcode and DIV-by-zero spend 1 EXEC cycle: out_valid rises 2 edges after the accepting edge.
REQ-021 MUL and DIV (operand_2 != 0) spend WIDTH EXEC cycles, one bit per cycle: out_valid rises WIDTH+1 edges after the accepting edge.
REQ-022 MUL is shift-add on the 2*WIDTH product: result = low WIDTH bits; carry = 1 if any high bit is nonzero.
REQ-023 DIV is restoring division: result = floor(operand_1 / operand_2); remainder = operand_1 mod operand_2.
REQ-024 DIV by zero: result all-ones, remainder = operand_1, div_by_zero = 1, carry = 0.
REQ-025 All arithmetic wraps modulo 2^WIDTH; INC of all-ones gives 0 with carry 1; DEC of 0 gives all-ones with carry 1.
REQ-026 Illegal opcode: result 0, remainder 0, illegal_op = 1, zero = 1, carry = 0.
REQ-027 DONE holds result, remainder and all flags stable until the edge where out_ready = 1, then goes to IDLE.
REQ-028 No new request is accepted in the DONE cycle that retires a result; the next accept occurs no earlier than the following edge.
REQ-029 Operand inputs may change freely after acceptance without affecting the operation in flight.

Reset
REQ-030 While rst = 1 on an edge: state goes to IDLE, the iteration counter goes to 0, and result, remainder, carry, zero, div_by_zero, illegal_op and out_valid go to 0.
REQ-031 in_ready = 0 while rst is high and 1 in the first cycle after rst falls.
REQ-032 Reset during EXEC or DONE abandons the operation; no out_valid is produced for it.

Structure
REQ-033 WORD_SIZE and OPCODE_SIZE live in package constants; the opcode encodings and the FSM state enum live in package opcodes.
REQ-034 The iterative multiply/divide datapath is one sub-module, seq_muldiv_core, with start/done handshake, shared shift register and a WIDTH-cycle counter.

Verification (WIDTH = 19)
REQ-035 ADD 0x7FFFF + 0x00001 -> result 0, carry 1, zero 1, out_valid 2 edges after accept.
REQ-036 MUL 1000 * 600 -> result 75712, carry 1, out_valid 20 edges after accept.
REQ-037 DIV 100000 / 7 -> result 14285, remainder 5; DIV 5 / 0 -> result 0x7FFFF, remainder 5, div_by_zero 1, out_valid 2 edges after accept.
REQ-038 SUB 3 - 5 with out_ready held low 5 cycles -> result 0x7FFFE, carry 1, outputs stable throughout, in_ready 0 until the retire edge.
REQ-039 rst pulsed 8 cycles into a MUL -> no out_valid for that MUL, all outputs 0, in_ready 1 after rst falls; the next DEC 0 -> 0x7FFFF, carry 1.
REQ-040 Unused opcode value -> illegal_op 1, result 0, zero 1; back-to-back INC requests retire in order with no request dropped.

Source files
------------

// File: rtl/seq_arith_unit_pkg.sv
// Shared sizing constants, opcode encodings and controller state type
// for the sequential arithmetic unit.
package constants;
  localparam int WORD_SIZE   = 19;
  localparam int OPCODE_SIZE = 3;
endpackage

package opcodes;
  import constants::*;

  localparam logic [OPCODE_SIZE-1:0] OP_ADD = 3'd0;
  localparam logic [OPCODE_SIZE-1:0] OP_SUB = 3'd1;
  localparam logic [OPCODE_SIZE-1:0] OP_MUL = 3'd2;
  localparam logic [OPCODE_SIZE-1:0] OP_DIV = 3'd3;
  localparam logic [OPCODE_SIZE-1:0] OP_INC = 3'd4;
  localparam logic [OPCODE_SIZE-1:0] OP_DEC = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/seq_arith_unit_muldiv_core.sv
// Iterative shift-add multiplier / restoring divider sharing one {hi,lo}
// shift register; one bit per cycle, done pulses after WIDTH iterations.
module seq_muldiv_core
  import constants::*;
#(
  parameter int WIDTH = WORD_SIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    count;
  logic             busy;
  logic [WIDTH-1:0] cur_hi, cur_lo, nxt_hi, nxt_lo;
  logic [WIDTH:0]   sum, shifted;

  // The start cycle already performs the first iteration on freshly loaded operands.
  always_comb begin
    cur_hi  = start ? '0 : hi;
    cur_lo  = start ? a : lo;
    sum     = '0;
    shifted = '0;
    nxt_hi  = cur_hi;
    nxt_lo  = cur_lo;
    if (is_div) begin
      shifted = {cur_hi, cur_lo[WIDTH-1]};
      if (shifted >= {1'b0, b}) begin
        sum    = shifted - {1'b0, b};
        nxt_hi = sum[WIDTH-1:0];
        nxt_lo = {cur_lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = shifted[WIDTH-1:0];
        nxt_lo = {cur_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum    = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, b} : '0);
      nxt_hi = sum[WIDTH:1];
      nxt_lo = {sum[0], cur_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      if (start || busy) begin
        hi <= nxt_hi;
        lo <= nxt_lo;
        if (start) begin
          busy  <= 1'b1;
          count <= CW'(1);
        end else if (count == CW'(WIDTH - 1)) begin
          busy  <= 1'b0;
          done  <= 1'b1;
          count <= '0;
        end else begin
          count <= count + CW'(1);
        end
      end
    end
  end
endmodule

// File: rtl/seq_arith_unit.sv
// Sequential arithmetic unit: single-request IDLE/EXEC/DONE controller with
// one-cycle add/sub/inc/dec and a WIDTH-cycle multiply/divide core.
module seq_arith_unit
  import constants::*, opcodes::*;
#(
  parameter int WIDTH = WORD_SIZE,
  parameter int OPW   = OPCODE_SIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   opcode,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             carry,
  output logic             zero,
  output logic             div_by_zero,
  output logic             illegal_op
);
  state_t           state;
  logic             first;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             is_div, is_md, core_done;
  logic [WIDTH-1:0] core_hi, core_lo;
  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] s_rem;
  logic             s_dbz, s_ill;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign is_div    = (op_q == OPW'(OP_DIV));
  assign is_md     = (op_q == OPW'(OP_MUL)) || (is_div && (b_q != '0));

  seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (state == EXEC && first && is_md),
    .is_div (is_div),
    .a      (a_q),
    .b      (b_q),
    .done   (core_done),
    .hi     (core_hi),
    .lo     (core_lo)
  );

  // Single-cycle results; the top bit of wide is carry-out or borrow.
  always_comb begin
    wide  = '0;
    s_rem = '0;
    s_dbz = 1'b0;
    s_ill = 1'b0;
    case (op_q)
      OPW'(OP_ADD): wide = {1'b0, a_q} + {1'b0, b_q};
      OPW'(OP_SUB): wide = {1'b0, a_q} - {1'b0, b_q};
      OPW'(OP_INC): wide = {1'b0, a_q} + (WIDTH+1)'(1);
      OPW'(OP_DEC): wide = {1'b0, a_q} - (WIDTH+1)'(1);
      OPW'(OP_MUL): wide = '0;
      OPW'(OP_DIV): begin
        wide  = {1'b0, {WIDTH{1'b1}}};
        s_rem = a_q;
        s_dbz = 1'b1;
      end
      default: s_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      first       <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result      <= '0;
      remainder   <= '0;
      carry       <= 1'b0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_q  <= opcode;
          a_q   <= operand_1;
          b_q   <= operand_2;
          first <= 1'b1;
          state <= EXEC;
        end
        // First EXEC cycle launches the core or registers the quick result.
        EXEC: if (first) begin
          first <= 1'b0;
          if (!is_md) begin
            result      <= wide[WIDTH-1:0];
            remainder   <= s_rem;
            carry       <= wide[WIDTH];
            zero        <= (wide[WIDTH-1:0] == '0);
            div_by_zero <= s_dbz;
            illegal_op  <= s_ill;
          end
        end else if (!is_md) begin
          state <= DONE;
        end else if (core_done) begin
          result      <= core_lo;
          remainder   <= is_div ? core_hi : '0;
          carry       <= is_div ? 1'b0 : (core_hi != '0);
          zero        <= (core_lo == '0);
          div_by_zero <= 1'b0;
          illegal_op  <= 1'b0;
          state       <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_arith_unit.sv
// Scoreboard bench for seq_arith_unit: driver pushes model expectations,
// an independent monitor checks every presented result and its latency.
module tb_seq_arith_unit;
  import constants::*;
  import opcodes::*;

  localparam int    W = 19;
  localparam int    OW = OPCODE_SIZE;
  localparam longint M = longint'(1) << W;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready;
  logic [OW-1:0] opcode;
  logic [W-1:0]  op1, op2, result, remainder;
  logic          carry, zero, dbz, ill;

  typedef struct {
    longint res, rem;
    bit c, z, d, i;
    int lat, acc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   hold_low = 0;
  bit   seen_first = 0;

  seq_arith_unit #(.WIDTH(W), .OPW(OW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .operand_1(op1), .operand_2(op2),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .remainder(remainder), .carry(carry), .zero(zero),
    .div_by_zero(dbz), .illegal_op(ill)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: plain integer arithmetic, reduced modulo 2^W.
  function automatic exp_t model(input logic [OW-1:0] op, input longint a, input longint b);
    exp_t   e;
    longint r;
    e.rem = 0; e.c = 0; e.d = 0; e.i = 0; e.lat = 2; e.acc = 0; r = 0;
    case (op)
      OP_ADD: begin r = a + b; e.c = (r >= M); end
      OP_SUB: begin r = a - b; e.c = (a < b); end
      OP_INC: begin r = a + 1; e.c = (r >= M); end
      OP_DEC: begin r = a - 1; e.c = (a == 0); end
      OP_MUL: begin r = a * b; e.c = (r >= M); e.lat = W + 1; end
      OP_DIV: if (b == 0) begin
        r = M - 1; e.rem = a; e.d = 1;
      end else begin
        r = a / b; e.rem = a % b; e.lat = W + 1;
      end
      default: begin r = 0; e.i = 1; end
    endcase
    e.res = ((r % M) + M) % M;
    e.z = (e.res == 0);
    return e;
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [OW-1:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input bit track);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1; opcode = op; op1 = a; op2 = b;
    while (!in_ready && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    if (track) begin
      e = model(op, a, b);
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    opcode = OW'($urandom);
    op1 = W'($urandom);
    op2 = W'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) checkOutput("drain_timeout", sb.size(), 0);
    @(posedge clk);
  endtask

  // Monitor: picks out_ready for the coming edge, then checks the presented result.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      seen_first = 0;
    end else begin
      if (out_valid && hold_low > 0) begin
        out_ready = 1'b0;
        hold_low--;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_valid", 1, 0);
        end else begin
          e = sb[0];
          if (!seen_first) begin
            checkOutput("latency", cyc - e.acc, e.lat);
            seen_first = 1;
          end
          checkOutput("result", result, e.res);
          checkOutput("remainder", remainder, e.rem);
          checkOutput("carry", carry, e.c);
          checkOutput("zero", zero, e.z);
          checkOutput("div_by_zero", dbz, e.d);
          checkOutput("illegal_op", ill, e.i);
          checkOutput("in_ready_in_done", in_ready, 0);
          if (out_ready) begin
            void'(sb.pop_front());
            seen_first = 0;
          end
        end
      end
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_out_valid"}, out_valid, 0);
    checkOutput({tag, "_result"}, result, 0);
    checkOutput({tag, "_remainder"}, remainder, 0);
    checkOutput({tag, "_flags"}, {carry, zero, dbz, ill}, 0);
    checkOutput({tag, "_in_ready"}, in_ready, 0);
  endtask

  initial begin
    logic [W-1:0] a, b;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; op1 = '0; op2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;
    #1 checkOutput("in_ready_after_reset", in_ready, 1);

    $display("[TB] directed operations");
    applyStimulus(OP_ADD, 19'h7FFFF, 19'h00001, 1);
    applyStimulus(OP_MUL, 19'd1000, 19'd600, 1);
    applyStimulus(OP_DIV, 19'd100000, 19'd7, 1);
    applyStimulus(OP_DIV, 19'd5, 19'd0, 1);
    drain();

    $display("[TB] backpressure hold");
    hold_low = 5;
    applyStimulus(OP_SUB, 19'd3, 19'd5, 1);
    drain();

    $display("[TB] reset during multiply");
    applyStimulus(OP_MUL, 19'd1234, 19'd4321, 0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkResetOutputs("midop_reset");
    rst = 1'b0;
    #1 checkOutput("in_ready_after_midop_reset", in_ready, 1);
    applyStimulus(OP_DEC, 19'd0, 19'd99, 1);
    drain();

    $display("[TB] illegal opcodes and back-to-back increments");
    applyStimulus(3'd6, 19'd77, 19'd88, 1);
    applyStimulus(3'd7, 19'h7FFFF, 19'd1, 1);
    applyStimulus(OP_INC, 19'h7FFFF, 19'd0, 1);
    applyStimulus(OP_INC, 19'd10, 19'd0, 1);
    applyStimulus(OP_INC, 19'd11, 19'd0, 1);
    applyStimulus(OP_INC, 19'd0, 19'd0, 1);
    drain();

    $display("[TB] randomized operations");
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 3))
        0: a = '0;
        1: a = '1;
        default: a = W'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0: b = '0;
        1: b = '1;
        2: b = W'($urandom_range(1, 15));
        default: b = W'($urandom);
      endcase
      applyStimulus(OW'($urandom_range(0, 7)), a, b, 1);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
